// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between two
// requesters, holding operands for the op's execution time and pulsing the result back.
module alu_share_arbiter #(
    parameter int SIZE        = 32,
    parameter int MULT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [3:0]      req0_op,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [3:0]      req1_op,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    output logic            req1_ready,
    output logic [3:0]      alu_op,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            resp0_valid,
    output logic            resp1_valid,
    output logic [SIZE-1:0] resp_out,
    output logic            resp_zero,
    output logic            resp_overflow,
    output logic [1:0]      dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd6;
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [SIZE-1:0] alu_a_q, alu_a_d;
    logic [SIZE-1:0] alu_b_q, alu_b_d;
    logic [SIZE-1:0] resp_out_q, resp_out_d;
    logic            resp_zero_q, resp_zero_d;
    logic            resp_ovf_q, resp_ovf_d;
    logic            grant0, grant1;
    logic [3:0]      sel_op;

    // Handshake: a request transfers in a cycle where reqN_valid && reqN_ready. Ready is
    // combinational, only raised in IDLE, and never to both requesters; on a tie the
    // requester that did not win last time is chosen.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant_q);
            grant1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    assign sel_op = grant1 ? req1_op : req0_op;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        resp_out_d   = resp_out_q;
        resp_zero_d  = resp_zero_q;
        resp_ovf_d   = resp_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    alu_op_d     = sel_op;
                    alu_a_d      = grant1 ? req1_a : req0_a;
                    alu_b_d      = grant1 ? req1_b : req0_b;
                    cnt_d        = (sel_op == OP_MULT) ? MULT_CNT : 4'd1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    resp_out_d  = alu_out;
                    resp_zero_d = alu_zero;
                    // Overflow only carries meaning for the arithmetic ops.
                    resp_ovf_d  = alu_overflow && ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB));
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                alu_op_d = 4'd0;
                alu_a_d  = '0;
                alu_b_d  = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            alu_op_q     <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            resp_out_q   <= '0;
            resp_zero_q  <= 1'b0;
            resp_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            resp_out_q   <= resp_out_d;
            resp_zero_q  <= resp_zero_d;
            resp_ovf_q   <= resp_ovf_d;
        end
    end

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign resp0_valid   = (state_q == S_RESP) && !owner_q;
    assign resp1_valid   = (state_q == S_RESP) && owner_q;
    assign resp_out      = resp_out_q;
    assign resp_zero     = resp_zero_q;
    assign resp_overflow = resp_ovf_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU closes the loop, and
// hand-computed results, latencies and grant orders are compared cycle by cycle.
module tb_alu_share_arbiter;

    localparam int SIZE = 32;
    localparam int MC   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req1_valid;
    logic [3:0]      req0_op, req1_op;
    logic [SIZE-1:0] req0_a, req0_b, req1_a, req1_b;
    logic            req0_ready, req1_ready;
    logic [3:0]      alu_op;
    logic [SIZE-1:0] alu_a, alu_b, alu_out;
    logic            alu_zero, alu_overflow;
    logic            resp0_valid, resp1_valid;
    logic [SIZE-1:0] resp_out;
    logic            resp_zero, resp_overflow;
    logic [1:0]      dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    alu_share_arbiter #(.SIZE(SIZE), .MULT_CYCLES(MC)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_out(resp_out), .resp_zero(resp_zero), .resp_overflow(resp_overflow),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: overflow is carry-out for ADD, borrow for SUB, high half for MULT.
    logic [SIZE:0]     sum_w;
    logic [2*SIZE-1:0] prod_w;
    always_comb begin
        sum_w        = {1'b0, alu_a} + {1'b0, alu_b};
        prod_w       = {{SIZE{1'b0}}, alu_a} * {{SIZE{1'b0}}, alu_b};
        alu_out      = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'd1: alu_out = alu_a & alu_b;
            4'd2: alu_out = alu_a | alu_b;
            4'd3: begin alu_out = sum_w[SIZE-1:0]; alu_overflow = sum_w[SIZE]; end
            4'd4: begin alu_out = alu_a - alu_b; alu_overflow = (alu_a < alu_b); end
            4'd5: alu_out = (alu_a == alu_b) ? 1 : 0;
            4'd6: begin alu_out = prod_w[SIZE-1:0]; alu_overflow = |prod_w[2*SIZE-1:SIZE]; end
            4'd7: alu_out = ~(alu_a | alu_b);
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1 in IDLE; leaves at posedge+1 of the IDLE cycle after the response.
    task automatic run_single(input bit req, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int cnt, input logic [31:0] exp_out,
                              input logic exp_zero, input logic exp_ovf);
        bit seen;
        int lat;
        if (!req) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        else      begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        @(negedge clk);
        check("ready_win",  req ? req1_ready : req0_ready, 1);
        check("ready_lose", req ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                check("exec_op", alu_op, op);
                check("exec_a", alu_a, a);
                check("exec_b", alu_b, b);
                check("exec_noready", req0_ready | req1_ready, 0);
            end
        end
        if (!seen) check("resp_timeout", 0, 1);
        else begin
            check("resp_latency", lat, cnt + 1);
            check("resp0_valid", resp0_valid, !req);
            check("resp1_valid", resp1_valid, req);
            check("resp_out", resp_out, exp_out);
            check("resp_zero", resp_zero, exp_zero);
            check("resp_ovf", resp_overflow, exp_ovf);
            check("resp_noready", req0_ready | req1_ready, 0);
        end
        @(posedge clk); #1;
        check("post_resp_pulse", resp0_valid | resp1_valid, 0);
        check("post_resp_hold", resp_out, exp_out);
        check("post_alu_op", alu_op, 0);
        check("post_idle", dbg_state, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = '0; req1_b = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", dbg_state, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_resp_valid", resp0_valid | resp1_valid, 0);
        check("rst_resp_out", resp_out, 0);
        check("rst_flags", {resp_zero, resp_overflow}, 0);
        check("rst_ready", req0_ready | req1_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic ops, single requester
        run_single(0, 4'd3, 32'd5, 32'd7, 1, 32'd12, 0, 0);
        run_single(0, 4'd4, 32'd0, 32'd1, 1, 32'hFFFF_FFFF, 0, 1);
        run_single(1, 4'd5, 32'd9, 32'd9, 1, 32'd1, 0, 0);
        run_single(0, 4'd3, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1, 1);
        run_single(1, 4'd1, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 32'h0F00_0F00, 0, 0);
        run_single(0, 4'd7, 32'hF0F0_F0F0, 32'h0F0F_0000, 1, 32'h0000_0F0F, 0, 0);

        // MULT: held for MC cycles, overflow masked even when the ALU flags it
        run_single(1, 4'd6, 32'd3, 32'd4, MC, 32'd12, 0, 0);
        run_single(0, 4'd6, 32'h0001_0000, 32'h0001_0000, MC, 32'd0, 1, 0);

        // Undefined opcodes
        run_single(1, 4'd15, 32'd1, 32'd1, 1, 32'd0, 1, 0);
        run_single(0, 4'd0, 32'd6, 32'd2, 1, 32'd0, 1, 0);

        // Leave a non-zero result captured, then abort a MULT in its 2nd EXEC cycle
        run_single(0, 4'd3, 32'd5, 32'd7, 1, 32'd12, 0, 0);
        req0_valid = 1'b1; req0_op = 4'd6; req0_a = 32'd3; req0_b = 32'd5;
        @(negedge clk);
        check("abort_ready", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_exec2_state", dbg_state, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_state", dbg_state, 0);
        check("abort_alu_op", alu_op, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_resp_out", resp_out, 0);
        check("abort_no_pulse", resp0_valid | resp1_valid, 0);
        run_single(0, 4'd3, 32'd2, 32'd3, 1, 32'd5, 0, 0);

        // Both requesters continuously valid: req0 wins first tie after reset
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'h0000_00F0; req1_b = 32'h0000_003C;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("rr_ready0", req0_ready, (c % 6) == 0);
            check("rr_ready1", req1_ready, (c % 6) == 3);
            check("rr_resp0", resp0_valid, (c % 6) == 2);
            check("rr_resp1", resp1_valid, (c % 6) == 5);
            if ((c % 6) == 2) check("rr_out0", resp_out, 32'h0000_00FF);
            if ((c % 6) == 5) check("rr_out1", resp_out, 32'h0000_0030);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("rr_end_idle", dbg_state, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
